step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter WIDTH_OUT, default 8: number of decoder lines driven downstream.
REQ-002 SHALL have parameter WIDTH_IN, default $clog2(WIDTH_OUT): width of step/select value.
REQ-003 SHALL have parameters DELAY_RISE and DELAY_FALL, default 21 each: output propagation delays in time units.
REQ-004 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port Clear_bar  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Step_reset_bar  input  1  synchronous return of step to 0, active-low.
REQ-007 SHALL have port Load_bar  input  1  synchronous parallel load of D, active-low.
REQ-008 SHALL have port D  input  WIDTH_IN  parallel load value.
REQ-009 SHALL have port Count_en  input  1  advance step by one when running.
REQ-010 SHALL have port Stall  input  1  freeze step and disable decoder.
REQ-011 SHALL have port A  output  WIDTH_IN  current step, feeds 3-to-8 decoder select.
REQ-012 SHALL have ports Enable1_bar, Enable2_bar, Enable3  output  1 each  decoder enables.
REQ-013 SHALL have port RCO  output  1  terminal count: high when A==WIDTH_OUT-1, state RUN, Count_en=1, Stall=0, Step_reset_bar=1, Load_bar=1.

Function
REQ-014 SHALL implement states HOLD, RUN, STALL in a registered state machine.
REQ-015 SHALL transition HOLD -> RUN on the first rising edge after Clear_bar deasserts, A unchanged (0).
REQ-016 SHALL, in RUN with Stall=1 at an edge, transition to STALL; in STALL with Stall=0 at an edge, transition to RUN.
REQ-017 SHALL, in RUN or STALL, apply per-edge step priority: Step_reset_bar=0 -> A=0; else Load_bar=0 -> A=D; else (RUN, Stall=0, Count_en=1) -> A=A+1; else hold.
REQ-018 SHALL apply Step_reset_bar and Load_bar in STALL and on the edge entering STALL; counting only occurs when state is RUN and Stall=0.
REQ-019 SHALL ignore Step_reset_bar, Load_bar, Count_en and Stall in HOLD.
REQ-020 SHALL wrap A from WIDTH_OUT-1 to 0 on increment; when WIDTH_OUT < 2**WIDTH_IN, any value of A >= WIDTH_OUT (via load) SHALL increment to 0.
REQ-021 SHALL drive decoder enabled (Enable1_bar=0, Enable2_bar=0, Enable3=1) only in RUN; in HOLD and STALL SHALL drive Enable1_bar=1, Enable2_bar=1, Enable3=0.
REQ-022 SHALL derive all outputs from registered state and A, except RCO which is combinational from state, A and inputs per REQ-013.
REQ-023 SHALL apply DELAY_RISE/DELAY_FALL to every output via delayed continuous assignment.

Reset
REQ-024 SHALL, while Clear_bar=0, immediately force state HOLD, A=0, Enable1_bar=1, Enable2_bar=1, Enable3=0, RCO=0, independent of Clk.
REQ-025 SHALL, on Clear_bar asserted mid-count or mid-stall, abandon the current step and restart per REQ-015 after release.

Verification
REQ-026 Clear_bar=0 for 3 cycles then 1, Count_en=1 -> A=0 with enables off until first edge, then RUN, A=0,1,2,...,7,0 on successive edges; RCO=1 only while A=7.
REQ-027 RUN at A=3, Stall=1 for 2 edges, Count_en=1 -> A stays 3, Enable3=0, Enable1_bar=1 during STALL; Stall=0 -> RUN, A=3 at the next edge, then 4.
REQ-028 RUN at A=5, Load_bar=0, D=2, Step_reset_bar=0 same edge -> A=0 (reset wins); next edge Load_bar=0, D=6 -> A=6.
REQ-029 STALL at A=4, Load_bar=0, D=1 -> A=1 while still stalled; Stall=0 -> RUN, A=1, then 2 with Count_en=1.
REQ-030 RUN at A=6, Clear_bar pulsed low between edges -> A=0, enables off immediately; after release one HOLD edge, then counting resumes from 0.
REQ-031 WIDTH_OUT=6, Load_bar=0, D=7 in RUN, Count_en=1 -> A=7 then 0 on following edge; RCO=1 only while A=5.

Source files
------------

// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
//
// Sequences a step index (A) for a downstream 3-to-8 style decoder and drives
// the decoder's enable lines. A small FSM (HOLD / RUN / STALL) gates counting:
// after reset it spends one edge in HOLD, then runs. In RUN the step counts
// modulo WIDTH_OUT when Count_en is high. Raising Stall freezes the step and
// disables the decoder. Synchronous step reset and parallel load work in both
// RUN and STALL.
//
// Ports
//   Clk             in   rising-edge clock
//   Clear_bar       in   asynchronous active-low reset
//   Step_reset_bar  in   synchronous return of step to 0 (active-low)
//   Load_bar        in   synchronous parallel load of D (active-low)
//   D               in   [WIDTH_IN-1:0] load value
//   Count_en        in   advance step by one while running
//   Stall           in   freeze step and disable decoder
//   A               out  [WIDTH_IN-1:0] current step (decoder select)
//   Enable1_bar     out  decoder enable, active-low
//   Enable2_bar     out  decoder enable, active-low
//   Enable3         out  decoder enable, active-high
//   RCO             out  terminal count (combinational from state, A, inputs)
// ---------------------------------------------------------------------------
module step_sequencer #(
    parameter int WIDTH_OUT  = 8,
    parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
    parameter int DELAY_RISE = 21,
    parameter int DELAY_FALL = 21
) (
    input  logic                Clk,
    input  logic                Clear_bar,
    input  logic                Step_reset_bar,
    input  logic                Load_bar,
    input  logic [WIDTH_IN-1:0] D,
    input  logic                Count_en,
    input  logic                Stall,
    output logic [WIDTH_IN-1:0] A,
    output logic                Enable1_bar,
    output logic                Enable2_bar,
    output logic                Enable3,
    output logic                RCO
);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_STALL
    } state_t;

    localparam logic [WIDTH_IN-1:0] LAST_STEP = WIDTH_IN'(WIDTH_OUT - 1);

    state_t              state;
    logic [WIDTH_IN-1:0] a_q;
    logic                en_q;
    logic [WIDTH_IN-1:0] a_inc;
    logic                rco_c;

    // Anything at or past the last decoder line (reachable only by a load
    // when WIDTH_OUT is not a power of two) wraps straight to step 0.
    always_comb begin
        a_inc = (a_q >= LAST_STEP) ? '0 : a_q + 1'b1;
    end

    // NOTE: every register in this block is cleared by the async reset and
    // updated with non-blocking assignments, so all of them sample the same
    // pre-edge values of state and a_q.
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state <= ST_HOLD;
            a_q   <= '0;
            en_q  <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    // Control inputs are ignored here; the step stays 0.
                    state <= ST_RUN;
                    en_q  <= 1'b1;
                end
                ST_RUN, ST_STALL: begin
                    state <= Stall ? ST_STALL : ST_RUN;
                    en_q  <= !Stall;
                    if (!Step_reset_bar) begin
                        a_q <= '0;
                    end else if (!Load_bar) begin
                        a_q <= D;
                    end else if (state == ST_RUN && !Stall && Count_en) begin
                        a_q <= a_inc;
                    end
                end
                default: begin
                    state <= ST_HOLD;
                    a_q   <= '0;
                    en_q  <= 1'b0;
                end
            endcase
        end
    end

    // Terminal count flags the edge that will wrap the step back to 0.
    always_comb begin
        rco_c = Clear_bar && (state == ST_RUN) && (a_q == LAST_STEP) &&
                Count_en && !Stall && Step_reset_bar && Load_bar;
    end

    // Output propagation delays model the downstream timing of the part.
    assign #(DELAY_RISE, DELAY_FALL) A           = a_q;
    assign #(DELAY_RISE, DELAY_FALL) Enable1_bar = ~en_q;
    assign #(DELAY_RISE, DELAY_FALL) Enable2_bar = ~en_q;
    assign #(DELAY_RISE, DELAY_FALL) Enable3     = en_q;
    assign #(DELAY_RISE, DELAY_FALL) RCO         = rco_c;

endmodule

// File: tb/tb_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_step_sequencer
//
// Directed bench for step_sequencer. Two instances share all inputs: the
// default 8-step part (dut8) and a 6-step part (dut6) that exercises the
// non-power-of-two wrap. Outputs are sampled 30 time units after each rising
// edge, past the 21-unit output delay and well before the next edge.
// ---------------------------------------------------------------------------
module tb_step_sequencer;

    logic       Clk = 1'b0;
    logic       Clear_bar;
    logic       Step_reset_bar;
    logic       Load_bar;
    logic [2:0] D;
    logic       Count_en;
    logic       Stall;

    logic [2:0] a8, a6;
    logic       e1b8, e2b8, e38, rco8;
    logic       e1b6, e2b6, e36, rco6;

    int total  = 0;
    int passed = 0;

    always #50 Clk = ~Clk;

    step_sequencer dut8 (
        .Clk(Clk), .Clear_bar(Clear_bar), .Step_reset_bar(Step_reset_bar),
        .Load_bar(Load_bar), .D(D), .Count_en(Count_en), .Stall(Stall),
        .A(a8), .Enable1_bar(e1b8), .Enable2_bar(e2b8), .Enable3(e38),
        .RCO(rco8)
    );

    step_sequencer #(.WIDTH_OUT(6)) dut6 (
        .Clk(Clk), .Clear_bar(Clear_bar), .Step_reset_bar(Step_reset_bar),
        .Load_bar(Load_bar), .D(D), .Count_en(Count_en), .Stall(Stall),
        .A(a6), .Enable1_bar(e1b6), .Enable2_bar(e2b6), .Enable3(e36),
        .RCO(rco6)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Decoder enables of dut8: on means E1_bar=0, E2_bar=0, E3=1.
    task automatic check_en8(input string tag, input logic on);
        check({tag, ".en1_bar"}, 32'(e1b8), 32'(!on));
        check({tag, ".en2_bar"}, 32'(e2b8), 32'(!on));
        check({tag, ".en3"},     32'(e38),  32'(on));
    endtask

    task automatic tick();
        @(posedge Clk);
        #30;
    endtask

    initial begin
        Clear_bar      = 1'b0;
        Step_reset_bar = 1'b1;
        Load_bar       = 1'b1;
        D              = 3'd0;
        Count_en       = 1'b1;
        Stall          = 1'b0;

        // Reset held for three edges.
        tick(); tick(); tick();
        check("rst.a", 32'(a8), 32'd0);
        check_en8("rst", 1'b0);
        check("rst.rco", 32'(rco8), 32'd0);
        check("rst.a6", 32'(a6), 32'd0);

        // Released between edges: nothing changes until the next edge.
        Clear_bar = 1'b1;
        #40;
        check("rel.a", 32'(a8), 32'd0);
        check_en8("rel", 1'b0);

        // HOLD edge: enter RUN with A still 0.
        tick();
        check("hold.a", 32'(a8), 32'd0);
        check_en8("hold", 1'b1);
        check("hold.rco", 32'(rco8), 32'd0);

        // Count 1..7 then wrap to 0; RCO only while A=7.
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("cnt%0d.a", i), 32'(a8), 32'(i % 8));
            check($sformatf("cnt%0d.rco", i), 32'(rco8), 32'(i == 7));
        end

        // Advance to 3, then stall for two edges.
        tick(); tick(); tick();
        check("pre_stall.a", 32'(a8), 32'd3);
        Stall = 1'b1;
        tick();
        check("stall1.a", 32'(a8), 32'd3);
        check_en8("stall1", 1'b0);
        check("stall1.rco", 32'(rco8), 32'd0);
        tick();
        check("stall2.a", 32'(a8), 32'd3);
        check_en8("stall2", 1'b0);
        Stall = 1'b0;
        tick();
        check("unstall.a", 32'(a8), 32'd3);
        check_en8("unstall", 1'b1);
        tick();
        check("unstall_cnt.a", 32'(a8), 32'd4);

        // Step reset beats load on the same edge.
        tick();
        check("pre_prio.a", 32'(a8), 32'd5);
        Load_bar       = 1'b0;
        D              = 3'd2;
        Step_reset_bar = 1'b0;
        tick();
        check("prio.a", 32'(a8), 32'd0);
        Step_reset_bar = 1'b1;
        D              = 3'd6;
        tick();
        check("load6.a", 32'(a8), 32'd6);

        // Load applies on the edge entering STALL and while stalled.
        D     = 3'd4;
        Stall = 1'b1;
        tick();
        check("stall_load4.a", 32'(a8), 32'd4);
        check_en8("stall_load4", 1'b0);
        D = 3'd1;
        tick();
        check("stall_load1.a", 32'(a8), 32'd1);
        check_en8("stall_load1", 1'b0);
        Load_bar = 1'b1;
        Stall    = 1'b0;
        tick();
        check("resume.a", 32'(a8), 32'd1);
        check_en8("resume", 1'b1);
        tick();
        check("resume_cnt.a", 32'(a8), 32'd2);

        // Count to 6 and pulse Clear_bar between edges.
        tick(); tick(); tick(); tick();
        check("pre_clr.a", 32'(a8), 32'd6);
        #20;
        Clear_bar = 1'b0;
        #25;
        check("clr.a", 32'(a8), 32'd0);
        check_en8("clr", 1'b0);
        check("clr.rco", 32'(rco8), 32'd0);
        #5;
        Clear_bar = 1'b1;
        tick();
        check("clr_hold.a", 32'(a8), 32'd0);
        check_en8("clr_hold", 1'b1);
        tick();
        check("clr_cnt.a", 32'(a8), 32'd1);
        check("clr_cnt.a6", 32'(a6), 32'd1);

        // Six-step part: load 7, which increments straight to 0.
        Load_bar = 1'b0;
        D        = 3'd7;
        tick();
        check("w6_load.a6", 32'(a6), 32'd7);
        check("w6_load.rco6", 32'(rco6), 32'd0);
        Load_bar = 1'b1;
        #25;
        check("w6_load.rco8", 32'(rco8), 32'd1);
        tick();
        check("w6_wrap.a6", 32'(a6), 32'd0);
        check("w6_wrap.a8", 32'(a8), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("w6_cnt%0d.a6", i), 32'(a6), 32'(i));
            check($sformatf("w6_cnt%0d.rco6", i), 32'(rco6), 32'(i == 5));
        end
        // RCO also needs Count_en.
        Count_en = 1'b0;
        #25;
        check("w6_noen.rco6", 32'(rco6), 32'd0);
        Count_en = 1'b1;
        tick();
        check("w6_end.a6", 32'(a6), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
